// File: rtl/fetch_seq.sv
// fetch_seq -- multi-cycle Y86-64 instruction fetch unit.
//
// Reads one instruction from a byte-addressed instruction memory in beats of
// BEAT_BYTES bytes, sizes it from the icode nibble of the first byte and
// assembles icode/ifun/rA/rB/valC/valP for decode.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, pc           fetch request and address (taken only when idle)
//   mem_rd_en, mem_addr single-cycle beat read request and its byte address
//   mem_rd_data         beat data, byte i = mem[mem_addr+i]
//   mem_rd_valid        beat data valid (one read outstanding at most)
//   busy                high whenever not idle
//   out_valid/out_ready result handshake towards decode
//   icode, ifun, rA, rB, valC, valP, instr_valid, imem_error  fetch result
module fetch_seq #(
    parameter int ADDR_W     = 64,
    parameter int BEAT_BYTES = 1,
    parameter int MEM_BYTES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       pc,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [8*BEAT_BYTES-1:0] mem_rd_data,
    input  logic                    mem_rd_valid,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              icode,
    output logic [3:0]              ifun,
    output logic [3:0]              rA,
    output logic [3:0]              rB,
    output logic [63:0]             valC,
    output logic [ADDR_W-1:0]       valP,
    output logic                    instr_valid,
    output logic                    imem_error
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    // Instruction length in bytes from the icode nibble; undefined icodes
    // are treated as one-byte instructions.
    function automatic logic [3:0] f_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:         f_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:   f_len = 4'd2;
            4'h7, 4'h8:               f_len = 4'd9;
            4'h3, 4'h4, 4'h5:         f_len = 4'd10;
            default:                  f_len = 4'd1;
        endcase
    endfunction

    // ---------------------------------------------------------------- state
    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [3:0]          r_cnt;
    logic [7:0]          r_buf [10];
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_busy;
    logic                r_out_valid;
    logic [3:0]          r_icode;
    logic [3:0]          r_ifun;
    logic [3:0]          r_ra;
    logic [3:0]          r_rb;
    logic [63:0]         r_valc;
    logic [ADDR_W-1:0]   r_valp;
    logic                r_iv;
    logic                r_err;

    state_t              w_state_next;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [3:0]          w_cnt_next;
    logic [7:0]          w_buf_next [10];
    logic                w_mem_rd_en_next;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic [3:0]          w_icode_next;
    logic [3:0]          w_ifun_next;
    logic [3:0]          w_ra_next;
    logic [3:0]          w_rb_next;
    logic [63:0]         w_valc_next;
    logic [ADDR_W-1:0]   w_valp_next;
    logic                w_iv_next;
    logic                w_err_next;

    // ------------------------------------------------- beat merge into buffer
    logic [63:0] w_data64;
    logic [7:0]  w_merge [10];

    assign w_data64 = 64'(mem_rd_data);

    // Buffer slot gi takes beat byte (gi - cnt) when that byte belongs to the
    // current beat. Bytes whose address lies past the end of memory are
    // stored as zero so that partial results never carry stale data.
    for (genvar gi = 0; gi < 10; gi++) begin : g_merge
        logic [4:0] w_k;
        logic       w_take;
        logic       w_in_range;

        assign w_k        = 5'(gi) - {1'b0, r_cnt};
        assign w_take     = (5'(gi) >= {1'b0, r_cnt}) && (w_k < 5'(BEAT_BYTES));
        assign w_in_range = (r_pc + ADDR_W'(gi)) < MEM_LIMIT;
        assign w_merge[gi] = !w_take    ? r_buf[gi] :
                             w_in_range ? w_data64[8*w_k[2:0] +: 8] : 8'h00;
    end

    // ------------------------------------------------------ length / fields
    logic [3:0]        w_len;
    logic [4:0]        w_cnt_sum;
    logic [3:0]        w_cnt_new;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_need_err;
    logic [3:0]        w_asm_ra;
    logic [3:0]        w_asm_rb;
    logic [63:0]       w_asm_valc;

    // Byte 0 is always present in w_merge once the first beat has arrived.
    assign w_len       = f_len(w_merge[0][7:4]);
    assign w_cnt_sum   = {1'b0, r_cnt} + 5'(BEAT_BYTES);
    assign w_cnt_new   = (w_cnt_sum > 5'd10) ? 4'd10 : w_cnt_sum[3:0];
    assign w_next_addr = r_pc + ADDR_W'(w_cnt_new);
    // pc is below MEM_BYTES here, so the sum cannot wrap.
    assign w_need_err  = (r_pc + ADDR_W'(w_len)) > MEM_LIMIT;

    always_comb begin
        w_asm_ra   = 4'hF;
        w_asm_rb   = 4'hF;
        w_asm_valc = '0;
        if (w_len == 4'd2 || w_len == 4'd10) begin
            w_asm_ra = w_merge[1][7:4];
            w_asm_rb = w_merge[1][3:0];
        end
        for (int j = 0; j < 8; j++) begin
            if (w_len == 4'd10) begin
                w_asm_valc[8*j +: 8] = w_merge[j+2];
            end else if (w_len == 4'd9) begin
                w_asm_valc[8*j +: 8] = w_merge[j+1];
            end
        end
    end

    // --------------------------------------------------------- next state
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_cnt_next       = r_cnt;
        w_buf_next       = r_buf;
        w_mem_rd_en_next = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_icode_next     = r_icode;
        w_ifun_next      = r_ifun;
        w_ra_next        = r_ra;
        w_rb_next        = r_rb;
        w_valc_next      = r_valc;
        w_valp_next      = r_valp;
        w_iv_next        = r_iv;
        w_err_next       = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_next  = pc;
                    w_cnt_next = '0;
                    for (int j = 0; j < 10; j++) begin
                        w_buf_next[j] = '0;
                    end
                    if (pc < MEM_LIMIT) begin
                        w_mem_rd_en_next = 1'b1;
                        w_mem_addr_next  = pc;
                        w_state_next     = S_WAIT;
                    end else begin
                        // No memory access: report a one-byte nop-like
                        // result flagged as a memory error.
                        w_state_next = S_DONE;
                        w_icode_next = 4'h1;
                        w_ifun_next  = 4'h0;
                        w_ra_next    = 4'hF;
                        w_rb_next    = 4'hF;
                        w_valc_next  = '0;
                        w_valp_next  = pc + ADDR_W'(1);
                        w_iv_next    = 1'b1;
                        w_err_next   = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (mem_rd_valid) begin
                    w_buf_next   = w_merge;
                    w_cnt_next   = w_cnt_new;
                    w_icode_next = w_merge[0][7:4];
                    w_ifun_next  = w_merge[0][3:0];
                    w_ra_next    = w_asm_ra;
                    w_rb_next    = w_asm_rb;
                    w_valc_next  = w_asm_valc;
                    w_valp_next  = r_pc + ADDR_W'(w_len);
                    w_iv_next    = (w_merge[0][7:4] <= 4'hB);
                    if (w_cnt_new >= w_len) begin
                        // A wide beat may run past the end of memory while
                        // still covering the whole instruction; the error
                        // flag then reflects whether every byte was legal.
                        w_state_next = S_DONE;
                        w_err_next   = w_need_err;
                    end else if (w_next_addr >= MEM_LIMIT) begin
                        w_state_next = S_DONE;
                        w_err_next   = 1'b1;
                    end else begin
                        w_mem_rd_en_next = 1'b1;
                        w_mem_addr_next  = w_next_addr;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_cnt       <= '0;
            for (int j = 0; j < 10; j++) begin
                r_buf[j] <= '0;
            end
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_icode     <= 4'h0;
            r_ifun      <= 4'h0;
            r_ra        <= 4'hF;
            r_rb        <= 4'hF;
            r_valc      <= '0;
            r_valp      <= '0;
            r_iv        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_cnt       <= w_cnt_next;
            r_buf       <= w_buf_next;
            r_mem_rd_en <= w_mem_rd_en_next;
            r_mem_addr  <= w_mem_addr_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            r_icode     <= w_icode_next;
            r_ifun      <= w_ifun_next;
            r_ra        <= w_ra_next;
            r_rb        <= w_rb_next;
            r_valc      <= w_valc_next;
            r_valp      <= w_valp_next;
            r_iv        <= w_iv_next;
            r_err       <= w_err_next;
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = r_mem_addr;
    assign busy        = r_busy;
    assign out_valid   = r_out_valid;
    assign icode       = r_icode;
    assign ifun        = r_ifun;
    assign rA          = r_ra;
    assign rB          = r_rb;
    assign valC        = r_valc;
    assign valP        = r_valp;
    assign instr_valid = r_iv;
    assign imem_error  = r_err;

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: one instance with 1-byte beats and one with
// 8-byte beats share the stimulus and a common byte memory.
module tb_fetch_seq;

    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] pc = '0;
    int          lat = 1;

    logic [7:0]  mem [0:MEM-1];

    int n_cmp = 0;
    int n_bad = 0;

    int BBS [2] = '{1, 8};

    typedef struct packed {
        logic        busy;
        logic        out_valid;
        logic        rd_en;
        logic [63:0] addr;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        iv;
        logic        err;
    } obs_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        iv;
        logic        err;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        int          nb;
        exp_t        e;
        int          off1;
        int          off8;
    } vec_t;

    obs_t obs [2];
    obs_t cap [2];
    int   got_off [2];
    int   got_rd [2];

    always #5 clk = ~clk;

    // ------------------------------------------------ DUTs and memories
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int BB = (gi == 0) ? 1 : 8;

        logic            rd_en;
        logic [63:0]     addr;
        logic [8*BB-1:0] rd_data = '0;
        logic            rd_valid = 1'b0;
        logic            busy;
        logic            out_valid;
        logic [3:0]      icode, ifun, ra, rb;
        logic [63:0]     valc, valp;
        logic            iv, err;
        logic            pend = 1'b0;
        int              wcnt = 0;
        logic [63:0]     paddr = '0;

        fetch_seq #(.ADDR_W(64), .BEAT_BYTES(BB), .MEM_BYTES(MEM)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
            .mem_rd_en(rd_en), .mem_addr(addr), .mem_rd_data(rd_data),
            .mem_rd_valid(rd_valid), .busy(busy), .out_valid(out_valid),
            .out_ready(out_ready), .icode(icode), .ifun(ifun), .rA(ra),
            .rB(rb), .valC(valc), .valP(valp), .instr_valid(iv),
            .imem_error(err)
        );

        function automatic logic [8*BB-1:0] beat(input logic [63:0] a);
            logic [8*BB-1:0] d;
            logic [63:0]     x;
            d = '0;
            for (int i = 0; i < BB; i++) begin
                x = a + 64'(i);
                d[8*i +: 8] = (x < 64'(MEM)) ? mem[x[9:0]] : 8'hA5;
            end
            return d;
        endfunction

        // Memory answers lat cycles after the request cycle.
        always @(posedge clk) begin
            rd_valid <= 1'b0;
            if (rd_en) begin
                if (lat <= 1) begin
                    rd_valid <= 1'b1;
                    rd_data  <= beat(addr);
                end else begin
                    pend  <= 1'b1;
                    wcnt  <= lat - 1;
                    paddr <= addr;
                end
            end else if (pend) begin
                if (wcnt <= 1) begin
                    rd_valid <= 1'b1;
                    rd_data  <= beat(paddr);
                    pend     <= 1'b0;
                end else begin
                    wcnt <= wcnt - 1;
                end
            end
        end

        assign obs[gi] = {busy, out_valid, rd_en, addr, icode, ifun, ra, rb,
                          valc, valp, iv, err};
    end

    // ------------------------------------------------------------ helpers
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_fields(string tag, int d, exp_t e);
        chk($sformatf("%s d%0d icode", tag, d), 64'(cap[d].icode), 64'(e.icode));
        chk($sformatf("%s d%0d ifun", tag, d),  64'(cap[d].ifun),  64'(e.ifun));
        chk($sformatf("%s d%0d rA", tag, d),    64'(cap[d].ra),    64'(e.ra));
        chk($sformatf("%s d%0d rB", tag, d),    64'(cap[d].rb),    64'(e.rb));
        chk($sformatf("%s d%0d valC", tag, d),  cap[d].valc,       e.valc);
        chk($sformatf("%s d%0d valP", tag, d),  cap[d].valp,       e.valp);
        chk($sformatf("%s d%0d iv", tag, d),    64'(cap[d].iv),    64'(e.iv));
        chk($sformatf("%s d%0d err", tag, d),   64'(cap[d].err),   64'(e.err));
    endtask

    task automatic chk_reset(string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d busy", tag, d),  64'(obs[d].busy),      64'(0));
            chk($sformatf("%s d%0d ov", tag, d),    64'(obs[d].out_valid), 64'(0));
            chk($sformatf("%s d%0d rden", tag, d),  64'(obs[d].rd_en),     64'(0));
            chk($sformatf("%s d%0d addr", tag, d),  obs[d].addr,           64'(0));
            chk($sformatf("%s d%0d icode", tag, d), 64'(obs[d].icode),     64'(0));
            chk($sformatf("%s d%0d ifun", tag, d),  64'(obs[d].ifun),      64'(0));
            chk($sformatf("%s d%0d rA", tag, d),    64'(obs[d].ra),        64'hF);
            chk($sformatf("%s d%0d rB", tag, d),    64'(obs[d].rb),        64'hF);
            chk($sformatf("%s d%0d valC", tag, d),  obs[d].valc,           64'(0));
            chk($sformatf("%s d%0d valP", tag, d),  obs[d].valp,           64'(0));
            chk($sformatf("%s d%0d iv", tag, d),    64'(obs[d].iv),        64'(0));
            chk($sformatf("%s d%0d err", tag, d),   64'(obs[d].err),       64'(0));
        end
    endtask

    // Called #1 after a rising edge; start is sampled on the next edge (T).
    // got_off counts cycles from T to out_valid high (1 = cycle T+1).
    task automatic run_txn(string tag, logic [63:0] p, int l);
        logic seen [2];
        lat   = l;
        pc    = p;
        start = 1'b1;
        for (int d = 0; d < 2; d++) begin
            seen[d]    = 1'b0;
            got_rd[d]  = 0;
            got_off[d] = 0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 300 && !(seen[0] && seen[1]); n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!seen[d]) begin
                    if (obs[d].rd_en) begin
                        chk($sformatf("%s d%0d rdaddr%0d", tag, d, got_rd[d]),
                            obs[d].addr, p + 64'(got_rd[d] * BBS[d]));
                        got_rd[d]++;
                    end
                    if (obs[d].out_valid) begin
                        seen[d]    = 1'b1;
                        got_off[d] = n + 1;
                        cap[d]     = obs[d];
                    end
                end
            end
            if (!(seen[0] && seen[1])) begin
                @(posedge clk);
                #1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d done", tag, d), 64'(seen[d]), 64'(1));
        end
    endtask

    task automatic handshake(string tag, int hold);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d ov_drop", tag, d), 64'(obs[d].out_valid), 64'(0));
            chk($sformatf("%s d%0d idle", tag, d),     64'(obs[d].busy),      64'(0));
        end
    endtask

    // Reference: decode straight from the instruction-set rules.
    function automatic exp_t model(logic [63:0] p, output int need);
        exp_t       e;
        logic [7:0] b [10];
        int         len;
        e = '{icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0,
              valp: p + 64'd1, iv: 1'b1, err: 1'b1};
        need = 0;
        if (p >= 64'(MEM)) return e;
        for (int j = 0; j < 10; j++) begin
            b[j] = (int'(p) + j < MEM) ? mem[int'(p) + j] : 8'h00;
        end
        e.icode = b[0][7:4];
        e.ifun  = b[0][3:0];
        case (e.icode)
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        e.iv = (e.icode <= 4'hB);
        e.ra = 4'hF;
        e.rb = 4'hF;
        if (len == 2 || len == 10) begin
            e.ra = b[1][7:4];
            e.rb = b[1][3:0];
        end
        e.valc = '0;
        for (int k = 0; k < 8; k++) begin
            if (len == 10) e.valc = e.valc | (64'(b[k+2]) << (8*k));
            if (len == 9)  e.valc = e.valc | (64'(b[k+1]) << (8*k));
        end
        e.valp = p + 64'(len);
        e.err  = (int'(p) + len > MEM);
        need   = (len < MEM - int'(p)) ? len : MEM - int'(p);
        return e;
    endfunction

    function automatic vec_t mk(logic [63:0] p, logic [79:0] by, int nb,
                                logic [3:0] ic, logic [3:0] fn, logic [3:0] ra,
                                logic [3:0] rb, logic [63:0] vc, logic [63:0] vp,
                                logic iv, logic er, int o1, int o8);
        vec_t v;
        v.pc    = p;
        v.bytes = by;
        v.nb    = nb;
        v.e     = '{icode: ic, ifun: fn, ra: ra, rb: rb, valc: vc, valp: vp,
                    iv: iv, err: er};
        v.off1  = o1;
        v.off8  = o8;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- test
    initial begin
        vec_t vt [16];
        exp_t e;
        int   need;
        int   exp_off;
        int   nbeat;
        int   r;
        logic [63:0] p;
        string tag;

        vt[0]  = mk(64'h0,   80'h0000_0000_0000_000A_F330, 10, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10,   64'd10,  1, 0, 21, 5);
        vt[1]  = mk(64'h20,  80'h0000_0000_0000_0001_0080,  9, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100,  64'h29,  1, 0, 19, 5);
        vt[2]  = mk(64'h3FF, 80'h60,                        1, 4'h6, 4'h0, 4'h0, 4'h0, 64'h0,    64'h401, 1, 1, 3,  3);
        vt[3]  = mk(64'd2000, 80'h0,                        0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,    64'd2001, 1, 1, 1, 1);
        vt[4]  = mk(64'h0,   80'hE0,                        1, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0,    64'h1,   0, 0, 3,  3);
        vt[5]  = mk(64'h5,   80'h10,                        1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,    64'h6,   1, 0, 3,  3);
        vt[6]  = mk(64'h40,  80'h2360,                      2, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0,    64'h42,  1, 0, 5,  3);
        vt[7]  = mk(64'h100, 80'h8877_6655_4433_2211_1540, 10, 4'h4, 4'h0, 4'h1, 4'h5, 64'h8877665544332211, 64'h10A, 1, 0, 21, 5);
        vt[8]  = mk(64'h200, 80'h0000_0000_00DE_ADBE_EF71,  9, 4'h7, 4'h1, 4'hF, 4'hF, 64'hDEADBEEF, 64'h209, 1, 0, 19, 5);
        vt[9]  = mk(64'h300, 80'h90,                        1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,    64'h301, 1, 0, 3,  3);
        vt[10] = mk(64'h310, 80'h4FA0,                      2, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0,    64'h312, 1, 0, 5,  3);
        vt[11] = mk(64'h3FA, 80'hDDCC_BBAA_F130,            6, 4'h3, 4'h0, 4'hF, 4'h1, 64'hDDCCBBAA, 64'h404, 1, 1, 13, 3);
        vt[12] = mk(64'h3FE, 80'h4521,                      2, 4'h2, 4'h1, 4'h4, 4'h5, 64'h0,    64'h400, 1, 0, 5,  3);
        vt[13] = mk(64'd1024, 80'h0,                        0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,    64'd1025, 1, 1, 1, 1);
        vt[14] = mk(64'h50,  80'hC5,                        1, 4'hC, 4'h5, 4'hF, 4'hF, 64'h0,    64'h51,  0, 0, 3,  3);
        vt[15] = mk(64'h60,  80'h00,                        1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,    64'h61,  1, 0, 3,  3);

        for (int i = 0; i < MEM; i++) mem[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("v%0d", i);
            for (int j = 0; j < vt[i].nb; j++) begin
                if (int'(vt[i].pc) + j < MEM) mem[int'(vt[i].pc) + j] = vt[i].bytes[8*j +: 8];
            end
            run_txn(tag, vt[i].pc, 1);
            for (int d = 0; d < 2; d++) begin
                chk_fields(tag, d, vt[i].e);
                exp_off = (d == 0) ? vt[i].off1 : vt[i].off8;
                chk($sformatf("%s d%0d latency", tag, d), 64'(got_off[d]), 64'(exp_off));
                chk($sformatf("%s d%0d reads", tag, d), 64'(got_rd[d]), 64'((exp_off - 1) / 2));
            end
            $display("txn %s pc=%h icode=%h valC=%h valP=%h iv=%b err=%b lat=%0d/%0d",
                     tag, vt[i].pc, cap[0].icode, cap[0].valc, cap[0].valp,
                     cap[0].iv, cap[0].err, got_off[0], got_off[1]);
            handshake(tag, 0);
        end

        // Hold in DONE with out_ready low: outputs stable, start ignored
        run_txn("hold", 64'h40, 1);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            pc    = 64'h100;
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("hold%0d d%0d ov", c, d),    64'(obs[d].out_valid), 64'(1));
                chk($sformatf("hold%0d d%0d rden", c, d),  64'(obs[d].rd_en),     64'(0));
                chk($sformatf("hold%0d d%0d icode", c, d), 64'(obs[d].icode),     64'h6);
                chk($sformatf("hold%0d d%0d rA", c, d),    64'(obs[d].ra),        64'h2);
                chk($sformatf("hold%0d d%0d valP", c, d),  obs[d].valp,           64'h42);
            end
        end
        start = 1'b0;
        $display("txn hold pc=0000000000000040 held 5 cycles with start pulses");
        handshake("hold", 0);
        // Next start right after the handshake must be taken at once.
        run_txn("b2b", 64'h5, 1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("b2b d%0d latency", d), 64'(got_off[d]), 64'(3));
            chk($sformatf("b2b d%0d icode", d), 64'(cap[d].icode), 64'h1);
            chk($sformatf("b2b d%0d valP", d), cap[d].valp, 64'h6);
        end
        $display("txn b2b pc=5 icode=%h valP=%h lat=%0d/%0d", cap[0].icode, cap[0].valp, got_off[0], got_off[1]);
        handshake("b2b", 0);

        // Reset with a read outstanding
        mem[16'h80] = 8'h30; mem[16'h81] = 8'hF7;
        for (int j = 2; j < 10; j++) mem[16'h80 + j] = 8'(j * 17);
        lat   = 3;
        pc    = 64'h80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("late%0d d%0d busy", c, d), 64'(obs[d].busy), 64'(0));
                chk($sformatf("late%0d d%0d ov", c, d),   64'(obs[d].out_valid), 64'(0));
            end
            @(posedge clk);
            #1;
        end
        $display("txn reset-mid-fetch pc=80 late beat ignored");
        run_txn("postrst", 64'h80, 1);
        e = model(64'h80, need);
        for (int d = 0; d < 2; d++) begin
            chk_fields("postrst", d, e);
            chk($sformatf("postrst d%0d valC", d), cap[d].valc, 64'h9988776655443322);
        end
        $display("txn postrst pc=80 icode=%h rB=%h valC=%h valP=%h", cap[0].icode, cap[0].rb, cap[0].valc, cap[0].valp);
        handshake("postrst", 0);

        // Randomized fetches against the reference model
        for (int t = 0; t < 60; t++) begin
            if (t % 15 == 0) begin
                for (int i = 0; i < MEM; i++) mem[i] = 8'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r < 6)      p = 64'($urandom_range(0, MEM - 1));
            else if (r < 9) p = 64'($urandom_range(MEM - 12, MEM - 1));
            else            p = 64'($urandom_range(MEM, MEM + 80));
            tag = $sformatf("r%0d", t);
            r = $urandom_range(1, 3);
            e = model(p, need);
            run_txn(tag, p, r);
            for (int d = 0; d < 2; d++) begin
                chk_fields(tag, d, e);
                nbeat   = (need + BBS[d] - 1) / BBS[d];
                exp_off = (need == 0) ? 1 : 1 + nbeat * (r + 1);
                chk($sformatf("%s d%0d latency", tag, d), 64'(got_off[d]), 64'(exp_off));
                chk($sformatf("%s d%0d reads", tag, d), 64'(got_rd[d]), 64'(nbeat));
            end
            $display("txn %s pc=%h lat=%0d icode=%h valC=%h valP=%h iv=%b err=%b cyc=%0d/%0d",
                     tag, p, r, cap[0].icode, cap[0].valc, cap[0].valp,
                     cap[0].iv, cap[0].err, got_off[0], got_off[1]);
            handshake(tag, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Parametrised multi-cycle Y86-64 instruction fetch unit. It sits between the PC register and the byte-addressed instruction memory. It reads an instruction in beats of BEAT_BYTES bytes, determines the instruction length from icode, and assembles icode/ifun/rA/rB/valC/valP. Results go to decode through a valid/ready handshake, with instruction-valid and memory-error status.

## Interface
- ADDR_W, 64, PC/address width; valP width
- BEAT_BYTES, 1, bytes returned per memory read; legal values 1, 2, 4, 8
- MEM_BYTES, 1024, instruction memory size; byte addresses >= MEM_BYTES are out of range
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  fetch request; accepted only in IDLE
- pc  in  ADDR_W  fetch address; sampled when start is accepted
- mem_rd_en  out  1  one-cycle read request
- mem_addr  out  ADDR_W  byte address of the beat
- mem_rd_data  in  8*BEAT_BYTES  byte i (bits 8i+7:8i) = mem[mem_addr+i]
- mem_rd_valid  in  1  data valid; latency >= 1 cycle after mem_rd_en
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  fetch result valid (DONE state)
- out_ready  in  1  decode accepts result
- icode, ifun, rA, rB  out  4 each  decoded fields
- valC  out  64  constant, little-endian
- valP  out  ADDR_W  pc + length, mod 2^ADDR_W
- instr_valid  out  1  icode in 0..B
- imem_error  out  1  any required byte out of range

## Operation
- States: IDLE, WAIT, DONE. A byte buffer holds 10 bytes; cnt is the number of bytes collected.
- IDLE, start=1: latch pc, clear buffer and cnt.
  - pc < MEM_BYTES: next cycle drive mem_rd_en=1 with mem_addr=pc; go to WAIT.
  - pc >= MEM_BYTES: go to DONE with imem_error=1, icode=1, ifun=0, rA=rB=F, valC=0, valP=pc+1, instr_valid=1.
- WAIT, mem_rd_valid=1: store data bytes into buffer[cnt..]; cnt += BEAT_BYTES, saturating at 10.
  - On the first beat, compute length from byte0[7:4]:
    - 0, 1, 9: length 1
    - 2, 6, A, B: length 2
    - 7, 8: length 9
    - 3, 4, 5: length 10
    - C..F: length 1 and instr_valid=0
  - If cnt >= length: go to DONE.
  - Else if pc+cnt >= MEM_BYTES: go to DONE with imem_error=1 and decoded fields retained.
  - Else: next cycle issue mem_rd_en with mem_addr=pc+cnt.
- Exactly one read outstanding at a time. mem_rd_en is a single-cycle pulse per beat.
- Field assembly:
  - icode=byte0[7:4], ifun=byte0[3:0].
  - Lengths 2 and 10: rA=byte1[7:4], rB=byte1[3:0]; otherwise rA=rB=F.
  - Length 10: valC=bytes 2..9. Length 9: valC=bytes 1..8. Otherwise valC=0.
  - Bytes beyond length are discarded.
- DONE: out_valid=1; all outputs hold stable until out_ready=1. On that edge go to IDLE and drop out_valid.
- start outside IDLE is ignored. mem_rd_valid outside WAIT is ignored.
- Reset, including mid-fetch:
  - State goes to IDLE.
  - mem_rd_en=0, mem_addr=0, out_valid=0, busy=0.
  - icode=ifun=0, rA=rB=F, valC=0, valP=0, instr_valid=0, imem_error=0.
  - Data returning after reset is ignored.

## Timing
- All outputs are registered.
- start accepted at edge T → mem_rd_en high in cycle T+1.
- With 1-cycle memory, beat k returns at T+2k. The next mem_rd_en follows in the cycle after each return.
- For B beats: out_valid rises in cycle T+2B+1, where B = ceil(length/BEAT_BYTES).
  - nop: T+3.
  - irmovq at BEAT_BYTES=1: T+21.
  - irmovq at BEAT_BYTES=8: T+5.
- Out-of-range pc: out_valid at T+1, no memory access.
- Back-to-back throughput: start is accepted the cycle after the out_ready handshake.
- Longer memory latency stretches WAIT only. There is no timeout.

## Test plan
- BEAT_BYTES=1, pc=0, mem = 30 F3 0A 00.. (irmovq $10,%rbx) → 10 reads at 0..9; icode=3, rA=F, rB=3, valC=10, valP=10, out_valid at T+21.
- BEAT_BYTES=8, pc=0x20, call 0x100 (80 00 01 00..) → 2 reads at 0x20 and 0x28; icode=8, valC=0x100, valP=0x29, rA=rB=F.
- pc=0x3FF with byte 0x60 (OPq), MEM_BYTES=1024 → one read; imem_error=1, icode=6, valP=0x401.
- pc=2000 → no mem_rd_en; imem_error=1, icode=1, valP=2001, out_valid at T+1. Byte 0xE0 at pc=0 → instr_valid=0, valP=1.
- out_ready held low 5 cycles in DONE → outputs stable, start pulses ignored; after out_ready=1, the next start is accepted.
- rst_n low while WAIT with a read outstanding → all outputs take reset values immediately; a late mem_rd_valid is ignored; the next fetch is correct.
